// File: rtl/jtpopeye_pkg.sv
`default_nettype none
// ==================================================================
// jtpopeye_pkg: object scanner / line-buffer shared definitions
// rev 1.0
// ==================================================================
package jtpopeye_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    YRD  = 3'd1,
    YCHK = 3'd2,
    ARD  = 3'd3,
    WR   = 3'd4,
    ENDM = 3'd5
  } objscan_state_t;

  // Y value marking an unused table entry
  localparam logic [7:0] OBJ_OFF = 8'hFF;

  localparam int BD_VALID = 31;
  localparam int BD_B3    = 24;
  localparam int BD_B2    = 16;
  localparam int BD_B1    = 8;
  localparam int BD_YOFF  = 0;

  typedef struct packed {
    logic       valid;
    logic [6:0] b3;
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] yoff;
  } objbuf_t;

endpackage
`default_nettype wire

// File: rtl/jtpopeye_objscan_cmp.sv
`default_nettype none
// ==================================================================
// jtpopeye_objscan_cmp: line offset and in-range test for one entry
// rev 1.0
// ==================================================================
module jtpopeye_objscan_cmp #(
  parameter int OBJH = 16
) (
  input  logic [7:0] v,
  input  logic [7:0] y,
  output logic [7:0] yoff,
  output logic       hit
);
  import jtpopeye_pkg::*;

  localparam logic [8:0] OBJH9 = 9'(OBJH);

  // modulo-256 so objects straddling the bottom wrap to line 0
  assign yoff = v + 8'd1 - y;
  assign hit  = (y != OBJ_OFF) && ({1'b0, yoff} < OBJH9);

endmodule
`default_nettype wire

// File: rtl/jtpopeye_objscan.sv
`default_nettype none
// ==================================================================
// jtpopeye_objscan: scans the 64-entry object table for line V+1
// rev 1.0
// ==================================================================
module jtpopeye_objscan #(
  parameter int OBJH   = 16,
  parameter int MAXOBJ = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        line_start,
  input  logic [7:0]  V,
  output logic [7:0]  obj_addr,
  input  logic [7:0]  obj_dout,
  output logic        buf_we,
  output logic [5:0]  buf_addr,
  output logic [31:0] buf_data,
  output logic        busy,
  output logic        ovf
);
  import jtpopeye_pkg::*;

  localparam logic [5:0] SLOT_MAX = 6'(MAXOBJ);

  objscan_state_t state, state_nxt;
  logic [5:0] entry, entry_nxt;
  logic [5:0] slot, slot_nxt;
  logic [1:0] bsel, bsel_nxt;
  logic [7:0] b1, b1_nxt;
  logic [7:0] b2, b2_nxt;
  logic [6:0] b3, b3_nxt;
  logic [7:0] yoff_r, yoff_nxt;
  logic [7:0] addr_nxt;
  logic       we, we_nxt;
  logic [5:0] baddr_nxt;
  objbuf_t    bdata, bdata_nxt;
  logic       busy_nxt, ovf_nxt;

  logic [7:0] yoff;
  logic       hit;

  jtpopeye_objscan_cmp #(.OBJH(OBJH)) u_cmp (
    .v    (V),
    .y    (obj_dout),
    .yoff (yoff),
    .hit  (hit)
  );

  // strobe only ever visible during an enabled cycle
  assign buf_we   = we & pxl_cen;
  assign buf_data = bdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (pxl_cen) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry    <= '0;
      slot     <= '0;
      bsel     <= '0;
      b1       <= '0;
      b2       <= '0;
      b3       <= '0;
      yoff_r   <= '0;
      obj_addr <= '0;
      we       <= 1'b0;
      buf_addr <= '0;
      bdata    <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else if (pxl_cen) begin
      entry    <= entry_nxt;
      slot     <= slot_nxt;
      bsel     <= bsel_nxt;
      b1       <= b1_nxt;
      b2       <= b2_nxt;
      b3       <= b3_nxt;
      yoff_r   <= yoff_nxt;
      obj_addr <= addr_nxt;
      we       <= we_nxt;
      buf_addr <= baddr_nxt;
      bdata    <= bdata_nxt;
      busy     <= busy_nxt;
      ovf      <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    entry_nxt = entry;
    slot_nxt  = slot;
    bsel_nxt  = bsel;
    b1_nxt    = b1;
    b2_nxt    = b2;
    b3_nxt    = b3;
    yoff_nxt  = yoff_r;
    addr_nxt  = obj_addr;
    we_nxt    = 1'b0;
    baddr_nxt = buf_addr;
    bdata_nxt = bdata;
    busy_nxt  = busy;
    ovf_nxt   = ovf;

    // a new line start always wins, discarding any scan in flight
    if (line_start) begin
      state_nxt = YRD;
      entry_nxt = '0;
      slot_nxt  = '0;
      ovf_nxt   = 1'b0;
      busy_nxt  = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        YRD: begin
          addr_nxt  = {entry, 2'd0};
          state_nxt = YCHK;
        end
        YCHK: begin
          if (hit && slot < SLOT_MAX) begin
            yoff_nxt  = yoff;
            addr_nxt  = {entry, 2'd1};
            bsel_nxt  = 2'd1;
            state_nxt = ARD;
          end else begin
            if (hit) ovf_nxt = 1'b1;
            if (entry == 6'd63) begin
              state_nxt = ENDM;
            end else begin
              entry_nxt = entry + 6'd1;
              state_nxt = YRD;
            end
          end
        end
        ARD: begin
          unique case (bsel)
            2'd1: begin
              b1_nxt   = obj_dout;
              addr_nxt = {entry, 2'd2};
              bsel_nxt = 2'd2;
            end
            2'd2: begin
              b2_nxt   = obj_dout;
              addr_nxt = {entry, 2'd3};
              bsel_nxt = 2'd3;
            end
            default: begin
              b3_nxt    = obj_dout[6:0];
              state_nxt = WR;
            end
          endcase
        end
        WR: begin
          we_nxt          = 1'b1;
          baddr_nxt       = slot;
          bdata_nxt.valid = 1'b1;
          bdata_nxt.b3    = b3;
          bdata_nxt.b2    = b2;
          bdata_nxt.b1    = b1;
          bdata_nxt.yoff  = yoff_r;
          slot_nxt        = slot + 6'd1;
          if (entry == 6'd63) begin
            state_nxt = ENDM;
          end else begin
            entry_nxt = entry + 6'd1;
            state_nxt = YRD;
          end
        end
        ENDM: begin
          if (slot < SLOT_MAX) begin
            we_nxt    = 1'b1;
            baddr_nxt = slot;
            bdata_nxt = '0;
          end
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtpopeye_objscan.sv
`default_nettype none
// ==================================================================
// tb_jtpopeye_objscan: table-driven and randomized scanner checks
// rev 1.0
// ==================================================================
module tb_jtpopeye_objscan;

  localparam int OBJH   = 16;
  localparam int MAXOBJ = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  V = 8'd0;
  logic [7:0]  obj_addr;
  logic [7:0]  obj_dout;
  logic        buf_we;
  logic [5:0]  buf_addr;
  logic [31:0] buf_data;
  logic        busy;
  logic        ovf;

  jtpopeye_objscan #(.OBJH(OBJH), .MAXOBJ(MAXOBJ)) dut (
    .clk        (clk),
    .rst        (rst),
    .pxl_cen    (pxl_cen),
    .line_start (line_start),
    .V          (V),
    .obj_addr   (obj_addr),
    .obj_dout   (obj_dout),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  assign obj_dout = mem[obj_addr];

  int cen_mode  = 0;   // 0 always on, 1 random, 2 held low
  bit cen_force = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (cen_force || cen_mode == 0) pxl_cen = 1'b1;
    else if (cen_mode == 1)         pxl_cen = 1'($urandom_range(0, 1));
    else                            pxl_cen = 1'b0;
  end

  logic [37:0] wq[$];
  int busy_ticks = 0;
  int we_off_cnt = 0;

  always @(negedge clk) begin
    if (buf_we) begin
      if (!pxl_cen) we_off_cnt++;
      else          wq.push_back({buf_addr, buf_data});
    end
    if (pxl_cen && busy) busy_ticks++;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the table with plain arithmetic
  logic [37:0] exp_q[$];
  bit          exp_ovf;
  int          exp_ticks;

  task automatic build_model(input logic [7:0] v);
    logic [7:0] line, y, yo;
    int cnt;
    exp_q.delete();
    exp_ovf   = 1'b0;
    exp_ticks = 1;
    cnt       = 0;
    line      = v + 8'd1;
    for (int e = 0; e < 64; e++) begin
      y  = mem[e*4];
      yo = line - y;
      if (y != 8'hFF && int'(yo) < OBJH) begin
        if (cnt < MAXOBJ) begin
          exp_q.push_back({6'(cnt), 1'b1, mem[e*4+3][6:0], mem[e*4+2], mem[e*4+1], yo});
          cnt++;
          exp_ticks += 6;
        end else begin
          exp_ovf = 1'b1;
          exp_ticks += 2;
        end
      end else begin
        exp_ticks += 2;
      end
    end
    if (cnt < MAXOBJ) exp_q.push_back({6'(cnt), 32'h0});
  endtask

  task automatic fill(input int e0, input int e1, input int lo, input int hi, input logic [7:0] y);
    for (int e = 0; e < 64; e++) begin
      mem[e*4]   = 8'hFF;
      mem[e*4+1] = 8'($urandom);
      mem[e*4+2] = 8'($urandom);
      mem[e*4+3] = 8'($urandom);
      if (e == e0 || e == e1 || (e >= lo && e <= hi)) mem[e*4] = y;
    end
  endtask

  task automatic fill_rand(input logic [7:0] v);
    int r;
    fill(-1, -1, 1, 0, 8'hFF);
    for (int e = 0; e < 64; e++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      mem[e*4] = 8'hFF;
      else if (r == 3) mem[e*4] = 8'($urandom);
      else             mem[e*4] = v + 8'd1 - 8'($urandom_range(0, 20));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] v);
    line_start = 1'b1;
    V          = v;
    cen_force  = 1'b1;
    tick();
    line_start = 1'b0;
    cen_force  = 1'b0;
    wq.delete();
    busy_ticks = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, " timeout"}, 64'(busy), 64'd0);
    cen_force = 1'b1;
    tick();
    tick();
    cen_force = 1'b0;
  endtask

  task automatic check_scan(input string name, input logic [7:0] v);
    int n;
    build_model(v);
    chk({name, " nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s write%0d", name, i), 64'(wq[i]), 64'(exp_q[i]));
    chk({name, " ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({name, " ticks"}, 64'(busy_ticks), 64'(exp_ticks));
  endtask

  typedef struct {
    int v; int e0; int e1; int lo; int hi; int y;
    int nwr; int ovf; int ticks; int valid0; int yoff0;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] rv;
    logic [81:0] snap;
    int changes;
    int n;

    //          v    e0  e1  lo hi  y    nwr ovf ticks val0 yoff0
    vecs[0] = '{10,  -1, -1, 1, 0,  255, 1,  0,  129,  0,   0};
    vecs[1] = '{9,   3,  40, 1, 0,  5,   3,  0,  137,  1,   5};
    vecs[2] = '{0,   -1, -1, 0, 63, 0,   32, 1,  257,  1,   1};
    vecs[3] = '{0,   -1, -1, 0, 31, 0,   32, 0,  257,  1,   1};
    vecs[4] = '{3,   5,  -1, 1, 0,  250, 2,  0,  133,  1,   10};
    vecs[5] = '{9,   5,  -1, 1, 0,  250, 1,  0,  129,  0,   0};
    vecs[6] = '{255, 7,  -1, 1, 0,  0,   2,  0,  133,  1,   0};
    vecs[7] = '{24,  63, -1, 1, 0,  10,  2,  0,  133,  1,   15};
    vecs[8] = '{25,  63, -1, 1, 0,  10,  1,  0,  129,  0,   0};

    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset obj_addr", 64'(obj_addr), 64'd0);
    chk("reset buf_we",   64'(buf_we),   64'd0);
    chk("reset buf_addr", 64'(buf_addr), 64'd0);
    chk("reset buf_data", 64'(buf_data), 64'd0);
    chk("reset busy",     64'(busy),     64'd0);
    chk("reset ovf",      64'(ovf),      64'd0);

    cen_mode = 1;
    fill(0, 1, 2, 63, 8'd0);
    wq.delete();
    repeat (40) tick();
    chk("idle no writes", 64'(wq.size()), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);
    cen_mode = 0;

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      fill(vecs[i].e0, vecs[i].e1, vecs[i].lo, vecs[i].hi, 8'(vecs[i].y));
      pulse_start(8'(vecs[i].v));
      wait_done(nm, 600);
      chk({nm, " tbl nwr"},   64'(wq.size()), 64'(vecs[i].nwr));
      chk({nm, " tbl ovf"},   64'(ovf),       64'(vecs[i].ovf));
      chk({nm, " tbl ticks"}, 64'(busy_ticks), 64'(vecs[i].ticks));
      if (wq.size() > 0) begin
        chk({nm, " tbl slot0 addr"},  64'(wq[0][37:32]), 64'd0);
        chk({nm, " tbl slot0 valid"}, 64'(wq[0][31]),    64'(vecs[i].valid0));
        chk({nm, " tbl slot0 yoff"},  64'(wq[0][7:0]),   64'(vecs[i].yoff0));
      end
      check_scan(nm, 8'(vecs[i].v));
    end

    // restart mid-scan
    fill(-1, -1, 0, 63, 8'd0);
    pulse_start(8'd0);
    repeat (20) tick();
    chk("abort writes before restart", 64'(wq.size()), 64'd3);
    pulse_start(8'd0);
    wait_done("abort", 600);
    check_scan("abort", 8'd0);

    // clock enable held low mid-scan
    fill(3, 40, 1, 0, 8'd5);
    pulse_start(8'd9);
    repeat (8) tick();
    cen_mode = 2;
    #2;
    snap = {obj_addr, buf_addr, buf_data, busy, ovf, 34'd0};
    changes = 0;
    repeat (30) begin
      @(negedge clk);
      if ({obj_addr, buf_addr, buf_data, busy, ovf, 34'd0} !== snap) changes++;
      if (buf_we) changes++;
    end
    chk("freeze changes", 64'(changes), 64'd0);
    cen_mode = 0;
    tick();
    wait_done("freeze", 600);
    check_scan("freeze", 8'd9);

    // reset landing on a write
    fill(-1, -1, 0, 63, 8'd0);
    pulse_start(8'd0);
    n = 0;
    while (!buf_we && n < 100) begin
      tick();
      n++;
    end
    chk("rst found write", 64'(buf_we), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst buf_we",   64'(buf_we),   64'd0);
    chk("rst busy",     64'(busy),     64'd0);
    chk("rst obj_addr", 64'(obj_addr), 64'd0);
    chk("rst buf_addr", 64'(buf_addr), 64'd0);
    tick();
    rst = 1'b0;
    repeat (300) tick();
    chk("rst no writes", 64'(wq.size()), 64'd0);
    chk("rst still idle", 64'(busy), 64'd0);
    pulse_start(8'd0);
    wait_done("post rst", 600);
    check_scan("post rst", 8'd0);

    // randomized tables with a random clock enable
    cen_mode = 1;
    for (int k = 0; k < 8; k++) begin
      rv = 8'($urandom);
      fill_rand(rv);
      pulse_start(rv);
      wait_done($sformatf("rand%0d", k), 3000);
      check_scan($sformatf("rand%0d", k), rv);
    end
    cen_mode = 0;

    chk("we while cen low", 64'(we_off_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtpopeye_objscan.md
JTPOPEYE_OBJSCAN -- requirements
Module: jtpopeye_objscan

Interface
REQ-001 SHALL have parameter OBJH, default 16, meaning object height in lines.
REQ-002 SHALL have parameter MAXOBJ, default 32, meaning the maximum number of objects per line (at most 63).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pxl_cen, input, 1 bit: clock enable; all state advances only on clk edges with pxl_cen=1.
REQ-006 SHALL have port line_start, input, 1 bit: starts a scan for line V+1; sampled only when pxl_cen=1.
REQ-007 SHALL have port V, input, 8 bits: current line.
REQ-008 SHALL have port obj_addr, output, 8 bits: object table byte address {entry[5:0], byte[1:0]}.
REQ-009 SHALL have port obj_dout, input, 8 bits: table data, valid on the cen tick after obj_addr is set.
REQ-010 SHALL have port buf_we, output, 1 bit: line-buffer write strobe, high for one cen tick.
REQ-011 SHALL have port buf_addr, output, 6 bits: line-buffer slot.
REQ-012 SHALL have port buf_data, output, 32 bits: {valid, byte3[6:0], byte2, byte1, yoff[7:0]}.
REQ-013 SHALL have port busy, output, 1 bit: scan in progress.
REQ-014 SHALL have port ovf, output, 1 bit: more than MAXOBJ hits occurred on the last scan.

Function
REQ-015 SHALL use the states IDLE, YRD, YCHK, ARD, WR, ENDM.
REQ-016 IDLE SHALL leave state only on line_start: entry=0, slot=0, ovf=0, busy=1, then go to YRD.
REQ-017 YRD SHALL set obj_addr={entry,2'b00}, then go to YCHK.
REQ-018 YCHK SHALL compute yoff=(V+1-Y) mod 256, taking Y from obj_dout.
REQ-019 An entry SHALL be a hit when Y!=8'hFF and yoff<OBJH; Y=8'hFF means disabled.
REQ-020 On a miss, if entry=63 the FSM SHALL go to ENDM; otherwise entry SHALL increment and the FSM SHALL go to YRD (2 ticks per miss).
REQ-021 On a hit, the FSM SHALL go to ARD.
REQ-022 ARD SHALL read bytes 1, 2 and 3 on three consecutive ticks, latching each on the tick after its address is set, then go to WR.
REQ-023 WR SHALL assert buf_we for one tick with buf_addr=slot and valid=1, then increment slot (6 ticks per hit).
REQ-024 After WR, if slot reaches MAXOBJ and entries remain, any later hit SHALL set ovf=1 and be dropped without a write.
REQ-025 After WR, the FSM SHALL continue to YRD, or go to ENDM when entry=63.
REQ-026 ENDM SHALL write one terminator (valid=0, other fields 0) at buf_addr=slot when slot<MAXOBJ, and skip it when slot=MAXOBJ.
REQ-027 ENDM SHALL then clear busy and return to IDLE.
REQ-028 A line_start while busy SHALL abort the current scan and restart from REQ-016 on the same tick; no partial write SHALL occur on that tick.
REQ-029 yoff arithmetic SHALL be 8-bit modulo 256: V=255 scans line 0, and Y=250 with V+1=4 gives yoff=10.
REQ-030 buf_we SHALL never be asserted while pxl_cen=0, and SHALL be asserted at most once per tick.
REQ-031 Worst-case scan time SHALL be MAXOBJ*6 + (64-MAXOBJ)*2 + 1 ticks (257 at the defaults).
REQ-032 ovf SHALL hold until the next line_start.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE, entry=0, slot=0, obj_addr=0, buf_we=0, buf_addr=0, buf_data=0, busy=0 and ovf=0.
REQ-034 After rst is released, the block SHALL ignore everything until the first line_start, including during a scan interrupted by reset.

Structure
REQ-035 The state encoding, the 8'hFF disable code and the buf_data field offsets SHALL live in the shared package jtpopeye_pkg, which the line-buffer consumer also uses.
REQ-036 The in-range compare (yoff, hit) SHALL be the single sub-module jtpopeye_objscan_cmp; all else SHALL be flat.

Verification
REQ-037 Table all 8'hFF, line_start with V=10 -> exactly one write: slot 0, valid=0; busy drops after 129 ticks.
REQ-038 Entries 3 and 40 with Y=5, V=9 -> slot 0 = entry 3 with yoff=5, slot 1 = entry 40, terminator at slot 2, ovf=0.
REQ-039 All 64 entries with Y=0, V=0 -> 32 valid writes, no terminator, ovf=1, scan length 257 ticks.
REQ-040 Y=250, V=3 -> hit with yoff=10; Y=250, V=9 -> miss (yoff=16).
REQ-041 line_start reissued 20 ticks into a scan -> writes restart at slot 0 and the old scan's writes stop; with pxl_cen held low mid-scan, all outputs freeze.
REQ-042 rst asserted during WR -> buf_we=0 immediately and no writes occur until the next line_start.
